// File: rtl/alu_pkg.sv
// alu_pkg: ALU op codes, RV32 opcode/funct7 constants, issue FSM states and funct3 decode helpers
package alu_pkg;
  localparam logic [4:0] ALU_NULL = 5'd0, ALU_ID = 5'd1, ALU_INCR = 5'd2, ALU_DECR = 5'd3;
  localparam logic [4:0] ALU_ADD = 5'd4, ALU_SUB = 5'd5, ALU_SLL = 5'd6, ALU_SRL = 5'd7, ALU_SRA = 5'd8;
  localparam logic [4:0] ALU_MUL = 5'd9, ALU_MULH = 5'd10, ALU_MULHU = 5'd11, ALU_MULHSU = 5'd12;
  localparam logic [4:0] ALU_DIV = 5'd13, ALU_DIVU = 5'd14, ALU_REM = 5'd15, ALU_REMU = 5'd16;
  localparam logic [4:0] ALU_OR = 5'd17, ALU_XOR = 5'd18, ALU_AND = 5'd19, ALU_SLT = 5'd20, ALU_SLTU = 5'd21;
  localparam logic [6:0] OP = 7'b0110011, OP_IMM = 7'b0010011, LUI = 7'b0110111, AUIPC = 7'b0010111;
  localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000, F7_MULDIV = 7'b0000001;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} issue_state_t;
  function automatic logic [4:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000: return ALU_ADD;
      3'b001: return ALU_SLL;
      3'b010: return ALU_SLT;
      3'b011: return ALU_SLTU;
      3'b100: return ALU_XOR;
      3'b101: return ALU_SRL;
      3'b110: return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
  function automatic logic [4:0] muldiv_op(input logic [2:0] f3);
    case (f3)
      3'b000: return ALU_MUL;
      3'b001: return ALU_MULH;
      3'b010: return ALU_MULHSU;
      3'b011: return ALU_MULHU;
      3'b100: return ALU_DIV;
      3'b101: return ALU_DIVU;
      3'b110: return ALU_REM;
      default: return ALU_REMU;
    endcase
  endfunction
endpackage

// File: rtl/alu_decode.sv
// alu_decode: combinational RV32IM OP/OP-IMM/LUI/AUIPC decode into ALU op code and operands
module alu_decode import alu_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] pc,
  output logic [4:0]      op,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [4:0]      rd,
  output logic            is_muldiv,
  output logic            illegal
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic shift, alt_ok;
  logic [XLEN-1:0] imm, upper, shamt;
  assign opc = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign rd = instr[11:7];
  assign shift = f3 == 3'b001 || f3 == 3'b101;
  assign alt_ok = f3 == 3'b000 || f3 == 3'b101;
  assign imm = XLEN'($signed(instr[31:20]));
  assign upper = XLEN'($signed({instr[31:12], 12'b0}));
  assign shamt = XLEN'(instr[24:20]);
  assign is_muldiv = opc == OP && f7 == F7_MULDIV;
  always_comb begin
    op = ALU_NULL;
    a = '0;
    b = '0;
    illegal = 1'b0;
    if (is_muldiv) begin
      op = muldiv_op(f3);
      a = rs1;
      b = rs2;
    end else if (opc == OP && (f7 == F7_BASE || (f7 == F7_ALT && alt_ok))) begin
      op = f7 == F7_ALT ? (f3 == 3'b000 ? ALU_SUB : ALU_SRA) : base_op(f3);
      a = rs1;
      b = rs2;
    end else if (opc == OP_IMM && !shift) begin
      op = base_op(f3);
      a = rs1;
      b = imm;
    end else if (opc == OP_IMM && (f7 == F7_BASE || (f7 == F7_ALT && f3 == 3'b101))) begin
      op = f7 == F7_ALT ? ALU_SRA : base_op(f3);
      a = rs1;
      b = shamt;
    end else if (opc == LUI) begin
      op = ALU_ID;
      a = upper;
    end else if (opc == AUIPC) begin
      op = ALU_ADD;
      a = pc;
      b = upper;
    end else
      illegal = 1'b1;
  end
endmodule

// File: rtl/alu_issue.sv
// alu_issue: accepts one instruction, holds ALU inputs for the op's latency, registers the result
module alu_issue import alu_pkg::*; #(
  parameter int XLEN = 32,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_pc,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [4:0]      alu_op,
  input  logic [XLEN-1:0] alu_r,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);
  localparam int CW = $clog2(MULDIV_CYCLES + 1);
  issue_state_t state, state_next;
  logic [CW-1:0] count;
  logic [4:0] dec_op, dec_rd, rd;
  logic [XLEN-1:0] dec_a, dec_b;
  logic dec_muldiv, dec_illegal, illegal, accept, last, out_free, capture;
  alu_decode #(.XLEN(XLEN)) u_decode (
    .instr(in_instr), .rs1(in_rs1), .rs2(in_rs2), .pc(in_pc), .op(dec_op), .a(dec_a), .b(dec_b),
    .rd(dec_rd), .is_muldiv(dec_muldiv), .illegal(dec_illegal)
  );
  assign accept = in_valid && in_ready;
  assign last = count == CW'(1);
  assign out_free = !out_valid || out_ready;
  assign capture = state == EXEC && last && out_free;
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_next;
  always_comb
    state_next = accept ? EXEC : capture ? DONE : (state == DONE && out_ready) ? IDLE : state;
  always_comb
    in_ready = state == IDLE || capture;
  // Operands change only on accept so the multicycle ALU path sees stable inputs, including stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      alu_op <= ALU_NULL;
      alu_a <= '0;
      alu_b <= '0;
      rd <= '0;
      illegal <= 1'b0;
      out_valid <= 1'b0;
      out_result <= '0;
      out_rd <= '0;
      out_illegal <= 1'b0;
    end else begin
      if (accept) begin
        count <= dec_muldiv ? CW'(MULDIV_CYCLES) : CW'(1);
        alu_op <= dec_op;
        alu_a <= dec_a;
        alu_b <= dec_b;
        rd <= dec_rd;
        illegal <= dec_illegal;
      end else if (capture)
        count <= '0;
      else if (state == EXEC && !last)
        count <= count - CW'(1);
      if (capture) begin
        out_valid <= 1'b1;
        out_result <= illegal ? '0 : alu_r;
        out_rd <= rd;
        out_illegal <= illegal;
      end else if (out_ready)
        out_valid <= 1'b0;
    end
  end
endmodule
